// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: fetches each sprite's next-line row from one shared ROM port during hblank
// and composites the buffered rows over the background during active video.
module sprite_line_scheduler #(
  parameter int N_SPR = 4,
  parameter int SHEET_W = 48,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END = 784,
  parameter int H_TOTAL = 800,
  parameter int V_VIS_START = 31,
  parameter int V_VIS_END = 511,
  parameter int V_TOTAL = 521,
  parameter logic [7:0] TRANSP = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic [N_SPR-1:0]   spr_en,
  input  logic [10*N_SPR-1:0] spr_x,
  input  logic [10*N_SPR-1:0] spr_y,
  input  logic [9*N_SPR-1:0] spr_hoff,
  input  logic [9*N_SPR-1:0] spr_voff,
  output logic [15:0]        rom_addr,
  input  logic [7:0]         rom_data,
  input  logic [7:0]         bg_rgb,
  output logic [7:0]         rgb,
  output logic               busy,
  output logic               overrun,
  output logic               collide
);
  localparam int IW = N_SPR > 1 ? $clog2(N_SPR) : 1;
  localparam logic [9:0] HVS = 10'(H_VIS_START);
  localparam logic [9:0] HVE = 10'(H_VIS_END);
  localparam logic [9:0] VVS = 10'(V_VIS_START);
  localparam logic [9:0] VVE = 10'(V_VIS_END);
  localparam logic [9:0] VLAST = 10'(V_TOTAL - 1);
  if (H_VIS_END >= H_TOTAL || V_VIS_END > V_TOTAL) begin : g_bad_timing
    $error("visible window exceeds total timing");
  end
  typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAIN, NEXT} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [4:0] cnt;
  logic [9:0] fl, nl, row, x_i, y_i;
  logic [8:0] ho_i, vo_i;
  logic [15:0] base, base_n;
  logic [N_SPR-1:0] valid, opq;
  logic [9:0] xl [N_SPR];
  logic [7:0] lbuf [N_SPR][16];
  logic [9:0] col [N_SPR];
  logic [7:0] pix;
  logic hit, start, abort, last, wr, vis, multi, frame0;
  assign nl = vcount == VLAST ? 10'd0 : vcount + 10'd1;
  assign x_i = spr_x[10*idx +: 10];
  assign y_i = spr_y[10*idx +: 10];
  assign ho_i = spr_hoff[9*idx +: 9];
  assign vo_i = spr_voff[9*idx +: 9];
  assign row = fl - y_i;
  assign hit = spr_en[idx] && row < 10'd16;
  assign base_n = 16'((32'(vo_i) + 32'(row)) * SHEET_W + 32'(ho_i));
  assign start = state == IDLE && hcount == HVE;
  assign abort = state != IDLE && hcount == HVS;
  assign last = idx == IW'(N_SPR - 1);
  assign wr = (state == FETCH && cnt != 5'd0) || state == DRAIN;
  assign busy = state != IDLE;
  assign vis = hcount >= HVS && hcount < HVE && vcount >= VVS && vcount < VVE;
  assign frame0 = hcount == 10'd0 && vcount == 10'd0;
  assign multi = |(opq & (opq - 1'b1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SCAN : IDLE;
      SCAN:    state_n = hit ? FETCH : NEXT;
      FETCH:   state_n = cnt == 5'd15 ? DRAIN : FETCH;
      DRAIN:   state_n = NEXT;
      default: state_n = last ? IDLE : SCAN;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      fl <= '0;
      base <= '0;
      rom_addr <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        idx <= '0;
        fl <= nl;
        valid <= '0;
      end
      if (!abort) begin
        if (state == SCAN && hit) begin
          base <= base_n;
          rom_addr <= base_n;
          cnt <= '0;
        end
        if (state == FETCH) begin
          cnt <= cnt + 5'd1;
          if (cnt != 5'd15) rom_addr <= base + 16'(cnt) + 16'd1;
        end
        if (state == DRAIN) valid[idx] <= 1'b1;
        if (state == NEXT && !last) idx <= idx + 1'b1;
      end
    end
  end
  // Buffer contents are only meaningful once the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (state == SCAN && hit && !abort) xl[idx] <= x_i;
    if (wr) lbuf[idx][cnt[3:0] - 4'd1] <= rom_data;
  end
  always_comb begin
    pix = bg_rgb;
    opq = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      col[i] = hcount - xl[i];
      opq[i] = valid[i] && col[i] < 10'd16 && lbuf[i][col[i][3:0]] != TRANSP;
      if (opq[i]) pix = lbuf[i][col[i][3:0]];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb <= '0;
      overrun <= 1'b0;
      collide <= 1'b0;
    end else begin
      rgb <= vis ? pix : 8'h00;
      overrun <= abort || (overrun && !frame0);
      collide <= (vis && multi) || (collide && !frame0);
    end
  end
endmodule
